cr16_decoder: RTL and testbench

//   Decode/issue stage directly upstream of cr16_alu. Accepts 16-bit CR16 instruction

---
 rtl/cr16_pkg.sv | 81 ++++++++
 rtl/cr16_decode_rom.sv | 116 +++++++++++
 rtl/cr16_decoder.sv | 125 ++++++++++++
 tb/tb_cr16_decoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// Shared encodings for the CR16 decode/issue stage and cr16_alu.
package cr16_pkg;

  // ALU opcodes as understood by cr16_alu
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_ADDU  = 4'd1;
  localparam logic [3:0] ALU_ADDC  = 4'd2;
  localparam logic [3:0] ALU_ADDCU = 4'd3;
  localparam logic [3:0] ALU_SUB   = 4'd4;
  localparam logic [3:0] ALU_SUBU  = 4'd5;
  localparam logic [3:0] ALU_AND   = 4'd6;
  localparam logic [3:0] ALU_OR    = 4'd7;
  localparam logic [3:0] ALU_XOR   = 4'd8;
  localparam logic [3:0] ALU_NOT   = 4'd9;
  localparam logic [3:0] ALU_LSH   = 4'd10;
  localparam logic [3:0] ALU_RSH   = 4'd11;
  localparam logic [3:0] ALU_ALSH  = 4'd12;
  localparam logic [3:0] ALU_ARSH  = 4'd13;

  // Major opcode field [15:12]
  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_ADDCI = 4'b0111;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;

  // EXT field [7:4] for OP_REG
  localparam logic [3:0] EXT_AND   = 4'b0001;
  localparam logic [3:0] EXT_OR    = 4'b0010;
  localparam logic [3:0] EXT_XOR   = 4'b0011;
  localparam logic [3:0] EXT_ADDCU = 4'b0100;
  localparam logic [3:0] EXT_ADD   = 4'b0101;
  localparam logic [3:0] EXT_ADDU  = 4'b0110;
  localparam logic [3:0] EXT_ADDC  = 4'b0111;
  localparam logic [3:0] EXT_SUB   = 4'b1001;
  localparam logic [3:0] EXT_SUBU  = 4'b1010;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_MOV   = 4'b1101;
  localparam logic [3:0] EXT_NOT   = 4'b1111;

  // EXT field [7:4] for OP_SHIFT register forms
  localparam logic [3:0] EXT_LSH  = 4'b0100;
  localparam logic [3:0] EXT_RSH  = 4'b0101;
  localparam logic [3:0] EXT_ALSH = 4'b0110;
  localparam logic [3:0] EXT_ARSH = 4'b0111;

  // Operand mux selects
  typedef enum logic [1:0] {
    SEL_RF   = 2'd0,
    SEL_IMM  = 2'd1,
    SEL_ZERO = 2'd2,
    SEL_FWD  = 2'd3
  } sel_e;

  // Everything stage D needs from one instruction word (immediate kept separate)
  typedef struct packed {
    logic [3:0] opcode;
    sel_e       a_sel;
    sel_e       b_sel;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       wb_en;
    logic [3:0] wb_addr;
  } decode_t;

  localparam decode_t DEC_NOP = '{
    opcode:  4'd0,
    a_sel:   SEL_RF,
    b_sel:   SEL_RF,
    ra:      4'd0,
    rb:      4'd0,
    wb_en:   1'b0,
    wb_addr: 4'd0
  };

endpackage

// File: rtl/cr16_decode_rom.sv
// Combinational instruction-word decoder: opcode, selects, addresses, immediate.
module cr16_decode_rom
  import cr16_pkg::*;
#(
  parameter int P_WIDTH = 16
) (
  input  logic [15:0]        i_instr,
  output decode_t            o_dec,
  output logic [P_WIDTH-1:0] o_imm,
  output logic               o_illegal
);

  logic [3:0] w_op;
  logic [3:0] w_rd;
  logic [3:0] w_ext;
  logic [3:0] w_rs;

  assign w_op  = i_instr[15:12];
  assign w_rd  = i_instr[11:8];
  assign w_ext = i_instr[7:4];
  assign w_rs  = i_instr[3:0];

  // Full decode table; anything unlisted is flagged illegal and never writes back
  always_comb begin
    o_dec     = DEC_NOP;
    o_imm     = '0;
    o_illegal = 1'b0;
    case (w_op)
      OP_REG: begin
        // A = RS, B = RD, result to RD
        o_dec.ra      = w_rs;
        o_dec.rb      = w_rd;
        o_dec.wb_addr = w_rd;
        o_dec.wb_en   = 1'b1;
        case (w_ext)
          EXT_ADD:   o_dec.opcode = ALU_ADD;
          EXT_ADDU:  o_dec.opcode = ALU_ADDU;
          EXT_ADDC:  o_dec.opcode = ALU_ADDC;
          EXT_ADDCU: o_dec.opcode = ALU_ADDCU;
          EXT_SUB:   o_dec.opcode = ALU_SUB;
          EXT_SUBU:  o_dec.opcode = ALU_SUBU;
          EXT_AND:   o_dec.opcode = ALU_AND;
          EXT_OR:    o_dec.opcode = ALU_OR;
          EXT_XOR:   o_dec.opcode = ALU_XOR;
          EXT_NOT:   o_dec.opcode = ALU_NOT;
          EXT_CMP: begin
            o_dec.opcode = ALU_SUB;
            o_dec.wb_en  = 1'b0;
          end
          EXT_MOV: begin
            // RD = RS + 0
            o_dec.opcode = ALU_ADDU;
            o_dec.b_sel  = SEL_ZERO;
          end
          default: o_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDCI, OP_SUBI, OP_CMPI: begin
        o_dec.ra      = w_rs;
        o_dec.rb      = w_rd;
        o_dec.wb_addr = w_rd;
        o_dec.wb_en   = (w_op != OP_CMPI);
        o_dec.a_sel   = SEL_IMM;
        o_imm         = {{(P_WIDTH-8){i_instr[7]}}, i_instr[7:0]};
        case (w_op)
          OP_ADDI:  o_dec.opcode = ALU_ADD;
          OP_ADDCI: o_dec.opcode = ALU_ADDC;
          default:  o_dec.opcode = ALU_SUB;
        endcase
      end
      OP_ADDUI, OP_ANDI, OP_ORI, OP_XORI: begin
        o_dec.ra      = w_rs;
        o_dec.rb      = w_rd;
        o_dec.wb_addr = w_rd;
        o_dec.wb_en   = 1'b1;
        o_dec.a_sel   = SEL_IMM;
        o_imm         = {{(P_WIDTH-8){1'b0}}, i_instr[7:0]};
        case (w_op)
          OP_ADDUI: o_dec.opcode = ALU_ADDU;
          OP_ANDI:  o_dec.opcode = ALU_AND;
          OP_ORI:   o_dec.opcode = ALU_OR;
          default:  o_dec.opcode = ALU_XOR;
        endcase
      end
      OP_SHIFT: begin
        // Shifts take the value on A (RD) and the amount on B (RS or imm)
        o_dec.ra      = w_rd;
        o_dec.rb      = w_rs;
        o_dec.wb_addr = w_rd;
        o_dec.wb_en   = 1'b1;
        casez (w_ext)
          EXT_LSH:  o_dec.opcode = ALU_LSH;
          EXT_RSH:  o_dec.opcode = ALU_RSH;
          EXT_ALSH: o_dec.opcode = ALU_ALSH;
          EXT_ARSH: o_dec.opcode = ALU_ARSH;
          4'b000?: begin
            o_dec.opcode = ALU_LSH;
            o_dec.b_sel  = SEL_IMM;
            o_imm        = {{(P_WIDTH-5){1'b0}}, i_instr[4:0]};
          end
          4'b001?: begin
            o_dec.opcode = ALU_RSH;
            o_dec.b_sel  = SEL_IMM;
            o_imm        = {{(P_WIDTH-5){1'b0}}, i_instr[4:0]};
          end
          default: o_illegal = 1'b1;
        endcase
      end
      default: o_illegal = 1'b1;
    endcase
    if (o_illegal) begin
      o_dec.wb_en = 1'b0;
    end
  end

endmodule

// File: rtl/cr16_decoder.sv
// CR16 decode/issue stage: D register feeds cr16_alu, W register aligns write-back.
module cr16_decoder
  import cr16_pkg::*;
#(
  parameter int P_WIDTH = 16,
  parameter int P_REGS  = 16
) (
  input  logic                       I_CLK,
  input  logic                       I_NRESET,
  input  logic [15:0]                I_INSTR,
  input  logic                       I_INSTR_VALID,
  output logic                       O_INSTR_READY,
  input  logic                       I_STALL,
  output logic                       O_ALU_ENABLE,
  output logic [3:0]                 O_ALU_OPCODE,
  output logic [$clog2(P_REGS)-1:0]  O_RA_ADDR,
  output logic [$clog2(P_REGS)-1:0]  O_RB_ADDR,
  output logic [1:0]                 O_A_SEL,
  output logic [1:0]                 O_B_SEL,
  output logic [P_WIDTH-1:0]         O_IMM,
  output logic                       O_WB_EN,
  output logic [$clog2(P_REGS)-1:0]  O_WB_ADDR,
  output logic                       O_ILLEGAL,
  output logic [15:0]                O_RETIRED
);

  decode_t              w_dec;
  logic [P_WIDTH-1:0]   w_imm;
  logic                 w_illegal;
  logic                 w_accept;
  logic                 w_alu_enable;
  logic                 w_w_live;

  decode_t              r_d;
  logic [P_WIDTH-1:0]   r_d_imm;
  logic                 r_d_valid;
  logic                 r_w_valid;
  logic                 r_w_wb_en;
  logic [3:0]           r_w_addr;
  logic                 r_illegal;
  logic [15:0]          r_retired;

  cr16_decode_rom #(
    .P_WIDTH (P_WIDTH)
  ) u_rom (
    .i_instr   (I_INSTR),
    .o_dec     (w_dec),
    .o_imm     (w_imm),
    .o_illegal (w_illegal)
  );

  assign w_accept     = I_INSTR_VALID & ~I_STALL;
  assign w_alu_enable = r_d_valid & ~I_STALL;
  assign w_w_live     = r_w_valid & r_w_wb_en;

  // Stage D: capture decoded fields on accept; illegal words never become valid
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_d       <= DEC_NOP;
      r_d_imm   <= '0;
      r_d_valid <= 1'b0;
    end else if (!I_STALL) begin
      r_d_valid <= w_accept & ~w_illegal;
      if (w_accept) begin
        r_d     <= w_dec;
        r_d_imm <= w_imm;
      end
    end
  end

  // Stage W: follows D one cycle later, matching the ALU result latency
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_w_valid <= 1'b0;
      r_w_wb_en <= 1'b0;
      r_w_addr  <= 4'd0;
    end else if (!I_STALL) begin
      r_w_valid <= r_d_valid;
      r_w_wb_en <= r_d.wb_en;
      r_w_addr  <= r_d.wb_addr;
    end
  end

  // Illegal flag is a single-cycle pulse after the offending word is taken
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept & w_illegal;
    end
  end

  // Retired counter: one per ALU issue, wraps naturally
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_retired <= 16'd0;
    end else if (w_alu_enable) begin
      r_retired <= r_retired + 16'd1;
    end
  end

  // Operand selects with forwarding from W; imm/zero selects are left alone
  always_comb begin
    O_A_SEL = r_d.a_sel;
    O_B_SEL = r_d.b_sel;
    if (r_d.a_sel == SEL_RF && w_w_live && r_w_addr == r_d.ra) begin
      O_A_SEL = SEL_FWD;
    end
    if (r_d.b_sel == SEL_RF && w_w_live && r_w_addr == r_d.rb) begin
      O_B_SEL = SEL_FWD;
    end
  end

  assign O_INSTR_READY = ~I_STALL;
  assign O_ALU_ENABLE  = w_alu_enable;
  assign O_ALU_OPCODE  = r_d.opcode;
  assign O_RA_ADDR     = r_d.ra;
  assign O_RB_ADDR     = r_d.rb;
  assign O_IMM         = r_d_imm;
  assign O_WB_EN       = w_w_live & ~I_STALL;
  assign O_WB_ADDR     = r_w_addr;
  assign O_ILLEGAL     = r_illegal;
  assign O_RETIRED     = r_retired;

endmodule

// File: tb/tb_cr16_decoder.sv
// Directed-vector bench for cr16_decoder.
module tb_cr16_decoder;

  logic        clk;
  logic        nreset;
  logic [15:0] instr;
  logic        valid;
  logic        ready;
  logic        stall;
  logic        alu_en;
  logic [3:0]  opcode;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [1:0]  a_sel;
  logic [1:0]  b_sel;
  logic [15:0] imm;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic        illegal;
  logic [15:0] retired;

  int n_total = 0;
  int n_bad   = 0;

  cr16_decoder #(
    .P_WIDTH (16),
    .P_REGS  (16)
  ) dut (
    .I_CLK         (clk),
    .I_NRESET      (nreset),
    .I_INSTR       (instr),
    .I_INSTR_VALID (valid),
    .O_INSTR_READY (ready),
    .I_STALL       (stall),
    .O_ALU_ENABLE  (alu_en),
    .O_ALU_OPCODE  (opcode),
    .O_RA_ADDR     (ra),
    .O_RB_ADDR     (rb),
    .O_A_SEL       (a_sel),
    .O_B_SEL       (b_sel),
    .O_IMM         (imm),
    .O_WB_EN       (wb_en),
    .O_WB_ADDR     (wb_addr),
    .O_ILLEGAL     (illegal),
    .O_RETIRED     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction offered for one cycle
  task automatic send(input logic [15:0] w);
    $display("[%0t] issue 0x%04h", $time, w);
    instr = w;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  initial begin
    int n_stream;
    nreset = 1'b0;
    stall  = 1'b0;
    valid  = 1'b0;
    instr  = 16'h0000;
    tick();
    tick();
    check("rst_en",      alu_en,  0);
    check("rst_wb",      wb_en,   0);
    check("rst_ill",     illegal, 0);
    check("rst_ret",     retired, 0);
    check("rst_op",      opcode,  0);
    check("rst_ra",      ra,      0);
    check("rst_rb",      rb,      0);
    check("rst_asel",    a_sel,   0);
    check("rst_bsel",    b_sel,   0);
    check("rst_imm",     imm,     0);
    nreset = 1'b1;
    tick();

    // ADD R5,R2
    send(16'h0552);
    check("add_en",   alu_en, 1);
    check("add_op",   opcode, 0);
    check("add_ra",   ra,     2);
    check("add_rb",   rb,     5);
    check("add_asel", a_sel,  0);
    check("add_bsel", b_sel,  0);
    check("add_wb0",  wb_en,  0);
    tick();
    check("add_wb1",  wb_en,  1);
    check("add_wba",  wb_addr, 5);
    check("add_en0",  alu_en, 0);
    tick();
    check("add_wb2",  wb_en,  0);
    check("add_ret",  retired, 1);

    // ADDI R3,-1 then ADDUI R3,0xFF
    send(16'h53FF);
    check("addi_op",   opcode, 0);
    check("addi_asel", a_sel,  1);
    check("addi_imm",  imm,    16'hFFFF);
    check("addi_rb",   rb,     3);
    send(16'h63FF);
    check("addui_op",   opcode, 1);
    check("addui_imm",  imm,    16'h00FF);
    check("addui_asel", a_sel,  1);
    check("addui_bsel", b_sel,  3);
    tick();
    tick();
    check("imm_ret", retired, 3);

    // CMP R3,R4: issues, never writes back
    send(16'h03B4);
    check("cmp_op", opcode, 4);
    check("cmp_en", alu_en, 1);
    check("cmp_ra", ra, 4);
    tick();
    check("cmp_wb1", wb_en, 0);
    tick();
    check("cmp_wb2", wb_en, 0);
    check("cmp_ret", retired, 4);

    // Forwarding: ADD R5,R2 ; ADDU R6,R5 ; ADDI R7,5
    send(16'h0552);
    send(16'h0665);
    check("fwd_asel",  a_sel, 3);
    check("fwd_ra",    ra,    5);
    check("fwd_bsel",  b_sel, 0);
    send(16'h5705);
    check("nofwd_asel", a_sel, 1);
    check("nofwd_bsel", b_sel, 0);
    tick();
    tick();
    check("fwd_ret", retired, 7);

    // Stall with D=ADDU R6 and W=ADD R5 both full
    send(16'h0552);
    $display("[%0t] issue 0x0665 (then stall)", $time);
    instr = 16'h0665;
    valid = 1'b1;
    tick();
    instr = 16'h5705;
    stall = 1'b1;
    #1;
    check("stl_rdy", ready,  0);
    check("stl_en",  alu_en, 0);
    check("stl_wb",  wb_en,  0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stl_en_h", alu_en, 0);
      check("stl_wb_h", wb_en,  0);
    end
    tick();
    stall = 1'b0;
    valid = 1'b0;
    #1;
    check("rel_rdy",  ready,   1);
    check("rel_en",   alu_en,  1);
    check("rel_op",   opcode,  1);
    check("rel_asel", a_sel,   3);
    check("rel_wb",   wb_en,   1);
    check("rel_wba",  wb_addr, 5);
    tick();
    check("rel_en2",  alu_en,  0);
    check("rel_wb2",  wb_en,   1);
    check("rel_wba2", wb_addr, 6);
    tick();
    check("rel_wb3",  wb_en,   0);
    check("rel_ret",  retired, 9);

    // Illegal words
    send(16'hF000);
    check("ill_pulse", illegal, 1);
    check("ill_en",    alu_en,  0);
    tick();
    check("ill_clr",   illegal, 0);
    check("ill_wb",    wb_en,   0);
    check("ill_ret",   retired, 9);
    send(16'h0000);
    check("ill0_pulse", illegal, 1);
    tick();

    // Shifts and MOV
    send(16'h8312);
    check("lshi_op",   opcode, 10);
    check("lshi_bsel", b_sel,  1);
    check("lshi_imm",  imm,    16'h0012);
    check("lshi_ra",   ra,     3);
    send(16'h8374);
    check("arsh_op",   opcode, 13);
    check("arsh_bsel", b_sel,  0);
    check("arsh_rb",   rb,     4);
    send(16'h02D1);
    check("mov_op",   opcode, 1);
    check("mov_bsel", b_sel,  2);
    check("mov_ra",   ra,     1);
    tick();
    tick();
    check("misc_ret", retired, 12);

    // Run the counter up to 0xFFFF, then wrap
    n_stream = 16'hFFFF - 12;
    $display("[%0t] stream %0d x 0x0552", $time, n_stream);
    instr = 16'h0552;
    valid = 1'b1;
    repeat (n_stream) tick();
    valid = 1'b0;
    tick();
    check("ret_max", retired, 16'hFFFF);
    send(16'h0552);
    tick();
    check("ret_wrap", retired, 0);

    // Reset while D and W are both occupied
    send(16'h0552);
    $display("[%0t] issue 0x0665 (then reset)", $time);
    instr = 16'h0665;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    #2;
    nreset = 1'b0;
    #1;
    check("mrst_en",   alu_en,  0);
    check("mrst_wb",   wb_en,   0);
    check("mrst_op",   opcode,  0);
    check("mrst_ra",   ra,      0);
    check("mrst_asel", a_sel,   0);
    check("mrst_ret",  retired, 0);
    check("mrst_wba",  wb_addr, 0);
    tick();
    nreset = 1'b1;
    tick();
    check("post_en", alu_en, 0);
    check("post_wb", wb_en,  0);
    tick();
    check("post_wb2", wb_en, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
